// File: rtl/maxpool_pkg.sv
// Shared definitions for the max-pool window generator: default geometry,
// derived vector and counter widths, and the window element index helper.
package maxpool_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_WIN        = 9;
    localparam int DEF_IMG_W      = 20;
    localparam int DEF_IMG_H      = 20;

    localparam int WIN_ELEMS = DEF_WIN * DEF_WIN;
    localparam int WINVEC_W  = DEF_DATA_WIDTH * WIN_ELEMS;
    localparam int COL_W     = $clog2(DEF_IMG_W);
    localparam int ROW_W     = $clog2(DEF_IMG_H);

    // Flat element index of window position (r, c); r=0 is the oldest row,
    // c=0 the oldest column.
    function automatic int win_idx(input int r, input int c, input int win);
        return r * win + c;
    endfunction

endpackage

// File: rtl/maxpool_line_delay.sv
// One image row of delay: a DEPTH-deep shift register that only moves when
// a pixel is accepted, so its output is the pixel directly above the input.
module maxpool_line_delay
    import maxpool_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_IMG_W
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    // Shift the row by one position on every accepted pixel, otherwise hold.
    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    // Storage only; contents are never emitted before being refilled.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/maxpool_window_gen.sv
// Turns a raster pixel stream into every fully populated WIN x WIN window
// (stride 1, valid mode), flattened for the downstream max tree.
// Optional macro MAXWIN_COORD_EN adds win_row/win_col, the frame position
// of each window's top-left pixel.
module maxpool_window_gen
    import maxpool_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int WIN        = DEF_WIN,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic                              win_valid,
    input  logic                              win_ready,
    output logic [0:DATA_WIDTH*WIN*WIN-1]     win_data,
    output logic                              win_last
`ifdef MAXWIN_COORD_EN
    ,
    output logic [$clog2(IMG_H)-1:0]          win_row,
    output logic [$clog2(IMG_W)-1:0]          win_col
`endif
);

    localparam int N_ELEMS = WIN * WIN;
    localparam int VEC_W   = DATA_WIDTH * N_ELEMS;
    localparam int C_W     = $clog2(IMG_W);
    localparam int R_W     = $clog2(IMG_H);

    localparam logic [C_W-1:0] COL_LAST      = C_W'(IMG_W - 1);
    localparam logic [R_W-1:0] ROW_LAST      = R_W'(IMG_H - 1);
    localparam logic [C_W-1:0] COL_FIRST_WIN = C_W'(WIN - 1);
    localparam logic [R_W-1:0] ROW_FIRST_WIN = R_W'(WIN - 1);

    logic [C_W-1:0]        col_q, col_d;
    logic [R_W-1:0]        row_q, row_d;
    logic                  win_valid_q, win_valid_d;
    logic                  win_last_q, win_last_d;
    logic [0:VEC_W-1]      win_data_q, win_data_d;
`ifdef MAXWIN_COORD_EN
    logic [R_W-1:0]        win_row_q, win_row_d;
    logic [C_W-1:0]        win_col_q, win_col_d;
`endif

    logic                  accept;
    logic                  trigger;
    logic [DATA_WIDTH-1:0] tap     [WIN-1];
    logic [DATA_WIDTH-1:0] new_col [WIN];
    logic [DATA_WIDTH-1:0] win_q   [WIN][WIN];
    logic [DATA_WIDTH-1:0] win_d   [WIN][WIN];
    logic [0:VEC_W-1]      win_vec;

    // A single output register: new input is taken whenever that register is
    // empty or being drained this cycle.
    assign in_ready = !win_valid_q || win_ready;
    assign accept   = in_valid && in_ready;
    assign trigger  = accept && (row_q >= ROW_FIRST_WIN) && (col_q >= COL_FIRST_WIN);

    // Chain of row delays; line k delivers the pixel k+1 rows above the input.
    for (genvar k = 0; k < WIN-1; k++) begin : g_line
        logic [DATA_WIDTH-1:0] din;
        if (k == 0) begin : g_first
            assign din = in_data;
        end else begin : g_next
            assign din = tap[k-1];
        end
        maxpool_line_delay #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_W)
        ) u_delay (
            .clk  (clk),
            .en   (accept),
            .din  (din),
            .dout (tap[k])
        );
    end

    // Incoming column, oldest row at the top and the new pixel at the bottom.
    always_comb begin
        for (int r = 0; r < WIN-1; r++) begin
            new_col[r] = tap[WIN-2-r];
        end
        new_col[WIN-1] = in_data;
    end

    // Window slides one column left per accepted pixel.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN-1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][WIN-1] = new_col[r];
            end
        end
    end

    // Flatten the post-shift window so the output register captures the
    // window that includes the pixel accepted on this edge.
    always_comb begin
        win_vec = '0;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                win_vec[win_idx(r, c, WIN)*DATA_WIDTH +: DATA_WIDTH] = win_d[r][c];
            end
        end
    end

    // Raster position of the next pixel to be accepted; frames run back to back.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + R_W'(1);
            end else begin
                col_d = col_q + C_W'(1);
            end
        end
    end

    // Output register: load on a window-producing accept, clear on drain,
    // hold everything while the consumer stalls.
    always_comb begin
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;
        win_data_d  = win_data_q;
        if (trigger) begin
            win_valid_d = 1'b1;
            win_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
            win_data_d  = win_vec;
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

`ifdef MAXWIN_COORD_EN
    // Top-left corner of the window sits WIN-1 rows and columns behind the
    // pixel that completed it.
    always_comb begin
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        if (trigger) begin
            win_row_d = row_q - ROW_FIRST_WIN;
            win_col_d = col_q - COL_FIRST_WIN;
        end
    end
`endif

    // Control and output registers; reset drops any pending window.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_data_q  <= '0;
`ifdef MAXWIN_COORD_EN
            win_row_q   <= '0;
            win_col_q   <= '0;
`endif
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            win_data_q  <= win_data_d;
`ifdef MAXWIN_COORD_EN
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
`endif
        end
    end

    // Window shift register; stale contents are masked by the counters.
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;
    assign win_data  = win_data_q;
`ifdef MAXWIN_COORD_EN
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
`endif

endmodule
